bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 99 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
//
// Purpose: FSM state encoding, the double-dabble adjust threshold and the
//          default operand/digit widths used by bin_to_bcd_seq and bcd_digit_adj.
// Ports:   none (package).

package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A BCD digit at or above this value would overflow past 9 when doubled,
  // so it is pre-corrected by +3 before the shift.
  localparam int ADJ_THRESHOLD = 5;

  localparam int DEF_BIN_W  = 16;
  localparam int DEF_DIGITS = 5;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational add-3 correction for one BCD digit
//
// Purpose: returns din + 3 when din >= 5, otherwise din unchanged.
// Ports:
//   din   in  [3:0]  scratch digit before the shift
//   dout  out [3:0]  corrected digit

module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'(ADJ_THRESHOLD)) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-add-3 binary to packed BCD converter
//
// Purpose: converts an unsigned BIN_W-bit operand to DIGITS packed BCD digits,
//          one operand bit per clock, MSB first.
// Ports:
//   clk     in   1          rising-edge clock
//   rst     in   1          asynchronous active-high reset
//   start   in   1          conversion request, honoured only in IDLE
//   binary  in   BIN_W      operand, captured on the accepting edge
//   bcd     out  4*DIGITS   last completed result, digit0 in [3:0]
//   busy    out  1          high in SHIFT and DONE
//   done    out  1          single-cycle pulse when bcd takes a new result

module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    binary,
  output logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SCR_W = 4 * DIGITS;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scratch_adj;
  logic [BIN_W-1:0]   shift_reg;

  // Per-digit correction of the current scratch, applied before the shift
  // in the same cycle.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[4*g +: 4]),
      .dout (scratch_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      // count==1 means this cycle performs the last of the BIN_W shifts.
      ST_SHIFT: if (count == CNT_W'(1)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      scratch   <= '0;
      shift_reg <= '0;
      bcd       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shift_reg <= binary;
            scratch   <= '0;
            count     <= CNT_W'(BIN_W);
          end
        end
        ST_SHIFT: begin
          {scratch, shift_reg} <= {scratch_adj[SCR_W-2:0], shift_reg, 1'b0};
          count                <= count - CNT_W'(1);
        end
        ST_DONE: begin
          bcd  <= scratch;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq

module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] binary;
  logic [19:0] bcd;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .binary (binary),
    .bcd    (bcd),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [19:0] b);
    int s;
    int w;
    s = 0;
    w = 1;
    for (int i = 0; i < 5; i++) begin
      s = s + int'(b[4*i +: 4]) * w;
      w = w * 10;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called and returns just after a falling edge.
  task automatic run_conv(input logic [15:0] val, output logic [19:0] res, output int lat);
    int k;
    binary = val;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 2) chk("busy_mid", busy, 1'b1);
    end
    lat = done ? k : -1;
    res = bcd;
    chk("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    logic [19:0] res;
    int lat;
    int ndone;
    int t0;
    int t1;
    int cyc;
    logic [19:0] r0;
    logic [19:0] r1;
    logic [15:0] v;
    logic digits_ok;

    rst    = 1'b1;
    start  = 1'b0;
    binary = '0;
    repeat (3) @(negedge clk);
    chk("reset_bcd", bcd, 20'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);

    // First start right after reset release, operand zero.
    rst = 1'b0;
    run_conv(16'd0, res, lat);
    chk("zero_latency", lat, 32'd17);
    chk("zero_bcd", res, 20'h00000);

    run_conv(16'd65535, res, lat);
    chk("max_bcd", res, 20'h65535);
    chk("max_latency", lat, 32'd17);
    run_conv(16'd9999, res, lat);
    chk("9999_bcd", res, 20'h09999);
    run_conv(16'd1023, res, lat);
    chk("1023_bcd", res, 20'h01023);

    // Start while busy is ignored, and bcd holds during the conversion.
    binary = 16'd255;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    res   = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        start  = 1'b1;
        binary = 16'd4096;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k == 10) chk("bcd_hold_busy", bcd, 20'h01023);
      if (done) begin
        ndone++;
        res = bcd;
      end
    end
    start = 1'b0;
    chk("ignore_done_count", ndone, 32'd1);
    chk("ignore_bcd", res, 20'h00255);

    // Reset in mid-conversion aborts with no done pulse.
    binary = 16'd12345;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_bcd", bcd, 20'h0);
    chk("abort_done", done, 1'b0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    chk("abort_bcd_after", bcd, 20'h0);
    run_conv(16'd12345, res, lat);
    chk("12345_bcd", res, 20'h12345);

    // Start held high: back-to-back conversions every 18 cycles.
    binary = 16'd1;
    start  = 1'b1;
    @(negedge clk);
    binary = 16'd10;
    ndone  = 0;
    t0 = 0; t1 = 0; r0 = '0; r1 = '0;
    cyc = 0;
    while (ndone < 2 && cyc < 60) begin
      if (done) begin
        if (ndone == 0) begin t0 = cyc; r0 = bcd; end
        else begin t1 = cyc; r1 = bcd; start = 1'b0; end
        ndone++;
      end
      if (ndone < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("held_done_count", ndone, 32'd2);
    chk("held_spacing", t1 - t0, 32'd18);
    chk("held_first", r0, 20'h00001);
    chk("held_second", r1, 20'h00010);
    repeat (3) @(negedge clk);

    // Random sweep against the arithmetic reference and its inverse.
    for (int n = 0; n < 2000; n++) begin
      v = 16'($urandom_range(0, 65535));
      run_conv(v, res, lat);
      digits_ok = 1'b1;
      for (int i = 0; i < 5; i++) if (res[4*i +: 4] > 4'd9) digits_ok = 1'b0;
      chk("rand_digits", digits_ok, 1'b1);
      chk("rand_roundtrip", from_bcd(res), int'(v));
      chk("rand_bcd", res, to_bcd(int'(v)));
      chk("rand_latency", lat, 32'd17);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
